// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the KGP-RISC execute stage.
//   - alu_op classes (ALU_OP_*) and R-type function codes (FUNC_*)
//   - 7-bit control word layout: [6:4] op, [3] inv_a, [2] cin, [1:0] branch
//   - ALU op codes, branch codes, pre-built control words
//   - FSM state encodings
package alu_pkg;

  // alu_op classes
  localparam logic [2:0] ALU_OP_RTYPE   = 3'b000;
  localparam logic [2:0] ALU_OP_LDST    = 3'b001;
  localparam logic [2:0] ALU_OP_BLTZ    = 3'b010;
  localparam logic [2:0] ALU_OP_BZ      = 3'b011;
  localparam logic [2:0] ALU_OP_BNZ     = 3'b100;
  localparam logic [2:0] ALU_OP_ADDI    = 3'b101;
  localparam logic [2:0] ALU_OP_COMPI   = 3'b110;
  localparam logic [2:0] ALU_OP_ILLEGAL = 3'b111;

  // R-type function field
  localparam logic [5:0] FUNC_ADD  = 6'd0;
  localparam logic [5:0] FUNC_COMP = 6'd1;
  localparam logic [5:0] FUNC_AND  = 6'd2;
  localparam logic [5:0] FUNC_XOR  = 6'd3;
  localparam logic [5:0] FUNC_SHLL = 6'd4;
  localparam logic [5:0] FUNC_SHRL = 6'd5;
  localparam logic [5:0] FUNC_SHRA = 6'd6;

  // Control word field positions
  localparam int CW_OP_HI = 6;
  localparam int CW_OP_LO = 4;
  localparam int CW_INV_A = 3;
  localparam int CW_CIN   = 2;
  localparam int CW_BR_HI = 1;
  localparam int CW_BR_LO = 0;

  // ALU op codes
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SHLL = 3'b011;
  localparam logic [2:0] OP_SHRL = 3'b100;
  localparam logic [2:0] OP_SHRA = 3'b101;

  // Branch codes
  localparam logic [1:0] BR_BZ   = 2'b00;
  localparam logic [1:0] BR_BNZ  = 2'b01;
  localparam logic [1:0] BR_BLTZ = 2'b10;
  localparam logic [1:0] BR_NONE = 2'b11;

  // Pre-built control words
  localparam logic [6:0] CW_AND  = {OP_AND,  1'b0, 1'b0, BR_NONE};
  localparam logic [6:0] CW_XOR  = {OP_XOR,  1'b0, 1'b0, BR_NONE};
  localparam logic [6:0] CW_ADD  = {OP_ADD,  1'b0, 1'b0, BR_NONE};
  // comp: ~a + 0 + 1 == -a
  localparam logic [6:0] CW_COMP = {OP_ADD,  1'b1, 1'b1, BR_NONE};
  localparam logic [6:0] CW_SHLL = {OP_SHLL, 1'b0, 1'b0, BR_NONE};
  localparam logic [6:0] CW_SHRL = {OP_SHRL, 1'b0, 1'b0, BR_NONE};
  localparam logic [6:0] CW_SHRA = {OP_SHRA, 1'b0, 1'b0, BR_NONE};
  localparam logic [6:0] CW_BLTZ = {OP_ADD,  1'b0, 1'b0, BR_BLTZ};
  localparam logic [6:0] CW_BZ   = {OP_ADD,  1'b0, 1'b0, BR_BZ};
  localparam logic [6:0] CW_BNZ  = {OP_ADD,  1'b0, 1'b0, BR_BNZ};

  // FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational decode of alu_op/func into the 7-bit ALU control word.
// Ports:
//   alu_op  in  [2:0]  operation class
//   func    in  [5:0]  function field (R-type only)
//   ctrl    out [6:0]  control word {op, inv_a, cin, branch}
//   illegal out        undecodable alu_op/func
// Illegal encodings produce a harmless AND/no-branch word so they can never
// resolve as a bz branch.
module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] func,
  output logic [6:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CW_AND;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_RTYPE: begin
        case (func)
          FUNC_ADD:  ctrl = CW_ADD;
          FUNC_COMP: ctrl = CW_COMP;
          FUNC_AND:  ctrl = CW_AND;
          FUNC_XOR:  ctrl = CW_XOR;
          FUNC_SHLL: ctrl = CW_SHLL;
          FUNC_SHRL: ctrl = CW_SHRL;
          FUNC_SHRA: ctrl = CW_SHRA;
          default:   illegal = 1'b1;
        endcase
      end
      ALU_OP_LDST:    ctrl = CW_ADD;
      ALU_OP_BLTZ:    ctrl = CW_BLTZ;
      ALU_OP_BZ:      ctrl = CW_BZ;
      ALU_OP_BNZ:     ctrl = CW_BNZ;
      ALU_OP_ADDI:    ctrl = CW_ADD;
      ALU_OP_COMPI:   ctrl = CW_COMP;
      ALU_OP_ILLEGAL: illegal = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: KGP-RISC execute stage. Decodes alu_op/func, executes the
// operation and presents result + flags on a valid/ready output port.
// Ports:
//   clk, rst (async, active high), flush (sync abort)
//   in_valid/in_ready, alu_op, func, a, b        request side
//   out_valid/out_ready, result, carry, zero,
//   sign, branch_taken, illegal                  response side
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and out_valid plus all response
// fields hold steady until the transfer completes.
// Non-shift ops are computed at accept and registered straight into the
// output registers. Shifts with a non-zero amount iterate in SHIFT, moving
// min(SHIFT_STEP, remaining) bits per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign,
  output logic              branch_taken,
  output logic              illegal
);

  // One extra bit so SHIFT_STEP == DATA_W is representable.
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

  logic [1:0]        state;
  logic [DATA_W-1:0] sh_reg;
  logic [CNT_W-1:0]  rem;
  logic [2:0]        sh_op;

  // Decode
  logic [6:0] ctrl;
  logic       dec_illegal;
  logic [2:0] cw_op;
  logic       cw_inv_a;
  logic       cw_cin;
  logic [1:0] cw_br;

  alu_decode u_decode (
    .alu_op  (alu_op),
    .func    (func),
    .ctrl    (ctrl),
    .illegal (dec_illegal)
  );

  assign cw_op    = ctrl[CW_OP_HI:CW_OP_LO];
  assign cw_inv_a = ctrl[CW_INV_A];
  assign cw_cin   = ctrl[CW_CIN];
  assign cw_br    = ctrl[CW_BR_HI:CW_BR_LO];

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);

  logic accept;
  assign accept = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the request operands
  logic [DATA_W-1:0] a_eff;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  shamt;
  logic              is_shift;
  logic              start_shift;
  logic [DATA_W-1:0] imm_result;
  logic              imm_carry;
  logic              imm_branch;

  assign a_eff = cw_inv_a ? ~a : a;
  assign b_eff = cw_inv_a ? '0 : b;
  assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cw_cin};
  assign shamt = {1'b0, b[SHAMT_W-1:0]};

  assign is_shift    = (cw_op == OP_SHLL) || (cw_op == OP_SHRL) || (cw_op == OP_SHRA);
  assign start_shift = is_shift && (shamt != '0);

  always_comb begin
    imm_result = a;  // shift by zero passes a through
    case (cw_op)
      OP_AND:  imm_result = a & b;
      OP_XOR:  imm_result = a ^ b;
      OP_ADD:  imm_result = sum[DATA_W-1:0];
      default: imm_result = a;
    endcase
    if (dec_illegal) imm_result = '0;
  end

  // Branch classes use the adder for the target but do not report carry.
  assign imm_carry = (cw_op == OP_ADD) && (cw_br == BR_NONE) && sum[DATA_W];

  always_comb begin
    imm_branch = 1'b0;
    case (cw_br)
      BR_BZ:   imm_branch = (a == '0);
      BR_BNZ:  imm_branch = (a != '0);
      BR_BLTZ: imm_branch = a[DATA_W-1];
      default: imm_branch = 1'b0;
    endcase
  end

  // Iterative shifter. Repeated arithmetic steps keep replicating the
  // original sign bit, so shra needs no separate fill register.
  logic [CNT_W-1:0]  step;
  logic [DATA_W-1:0] sh_next;
  logic              shift_last;

  assign step       = (rem < STEP) ? rem : STEP;
  assign shift_last = (rem <= STEP);

  always_comb begin
    case (sh_op)
      OP_SHLL: sh_next = sh_reg << step;
      OP_SHRL: sh_next = sh_reg >> step;
      default: sh_next = $signed(sh_reg) >>> step;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sh_reg       <= '0;
      rem          <= '0;
      sh_op        <= OP_SHLL;
      out_valid    <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      sign         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (start_shift) begin
              state     <= ST_SHIFT;
              out_valid <= 1'b0;
              sh_reg    <= a;
              rem       <= shamt;
              sh_op     <= cw_op;
            end else begin
              state        <= ST_DONE;
              out_valid    <= 1'b1;
              result       <= imm_result;
              carry        <= imm_carry;
              zero         <= (imm_result == '0) && !dec_illegal;
              sign         <= imm_result[DATA_W-1];
              branch_taken <= imm_branch;
              illegal      <= dec_illegal;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          sh_reg <= sh_next;
          rem    <= rem - step;
          if (shift_last) begin
            state        <= ST_DONE;
            out_valid    <= 1'b1;
            result       <= sh_next;
            carry        <= 1'b0;
            zero         <= (sh_next == '0);
            sign         <= sh_next[DATA_W-1];
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
